id_fwd_skid: RTL and testbench
==============================

ID_FWD_SKID -- requirements
Module: id_fwd_skid

Interface
REQ-001 Parameters SHALL be: WORD_W 32, operand/forward data width; ADDR_W 32, PC width; INSTR_W 32, instruction width; REG_IDX_W 5, register index width; SKID_DEPTH 2, buffer entries (power of two, >=2); NUM_FWD 3, forwarding sources, index 0 highest priority.
REQ-002 Ports SHALL be: clk  in  1  clock, rising edge; aresetn  in  1  asynchronous active-low reset.
REQ-003 clr  in  1  synchronous flush; i_valid  in  1  upstream entry valid; o_ready  out  1  buffer can accept.
REQ-004 i_pc  in  ADDR_W; i_instr  in  INSTR_W; i_use_a, i_use_b  in  1 each  instruction reads rs_a / rs_b.
REQ-005 o_rf_reg_a, o_rf_reg_b  out  REG_IDX_W  head's instr[19:15] / instr[24:20]; i_rf_data_a, i_rf_data_b  in  WORD_W  combinational register-file read data.
REQ-006 i_fwd_en  in  NUM_FWD; i_fwd_pending  in  NUM_FWD  (dest written later, data not ready); i_fwd_reg  in  NUM_FWD*REG_IDX_W; i_fwd_data  in  NUM_FWD*WORD_W; slot k at bits [k*W +: W].
REQ-007 o_valid  out  1; i_ready  in  1; o_pc  out  ADDR_W; o_instr  out  INSTR_W; o_dest_reg  out  REG_IDX_W  instr[11:7]; o_data_a, o_data_b  out  WORD_W.
REQ-008 o_hazard_cycles  out  16  saturating count of hazard-blocked cycles.

Function
REQ-009 Buffer SHALL be a circular FIFO of SKID_DEPTH entries {pc, instr, use_a, use_b} with read/write pointers and count of width clog2(SKID_DEPTH)+1; pointers wrap modulo SKID_DEPTH.
REQ-010 o_ready SHALL equal (count < SKID_DEPTH), derived from registered state only; push occurs when i_valid & o_ready.
REQ-011 Operand lookup per source s in {a,b}: if use_s=0 or index=0, operand=0 and no hazard; else lowest k with i_fwd_en[k] & i_fwd_reg[k]==index selects slot k; none matched -> i_rf_data_s.
REQ-012 If selected slot k has i_fwd_pending[k]=1, head SHALL be hazard-blocked; otherwise operand = i_fwd_data[k]; lower-priority matches SHALL be ignored even if not pending.
REQ-013 Output stage SHALL be a register {o_valid, o_pc, o_instr, o_dest_reg, o_data_a, o_data_b}; load_out = ~o_valid | i_ready.
REQ-014 On load_out: if head present and not blocked, head SHALL pop and its resolved operands SHALL load into the output register with o_valid=1; else o_valid SHALL become 0 (bubble).
REQ-015 While o_valid=1 and i_ready=0, all output fields SHALL hold and no pop SHALL occur.
REQ-016 Latency: entry pushed at edge n into empty buffer with no hazard and load_out SHALL appear on o_valid at edge n+1 (one cycle); sustained throughput one per cycle.
REQ-017 Simultaneous push and pop SHALL be legal at any count, count unchanged; push when full impossible (o_ready=0).
REQ-018 o_hazard_cycles SHALL increment each cycle head present, blocked, and load_out=1; saturates at 16'hFFFF.
REQ-019 clr=1 SHALL at next edge empty the FIFO, zero pointers, set o_valid=0, zero o_hazard_cycles; clr overrides push, pop and load; o_pc/o_instr/data need not clear.
REQ-020 Hazard state SHALL be re-evaluated each cycle; no blocked status is stored.

Reset
REQ-021 aresetn=0 SHALL immediately clear pointers, count, o_valid, o_pc, o_instr, o_dest_reg, o_data_a, o_data_b and o_hazard_cycles to 0; o_ready SHALL read 1 during and after reset.
REQ-022 Reset assertion mid-transfer SHALL discard all buffered entries; first push after deassertion behaves as into empty buffer.

Verification
REQ-023 Push pc=0x100 instr rs_a=3, rf_a=0x11, no fwd, i_ready=1 -> next cycle o_valid=1, o_pc=0x100, o_data_a=0x11.
REQ-024 rs_a=5; slot1 en reg5 data 0xAA; slot2 en reg5 data 0xBB -> o_data_a=0xAA; slot0 en reg5 pending -> bubble, o_hazard_cycles +1 per cycle until pending drops.
REQ-025 rs_b=0 with slot0 en reg0 pending, use_b=1 -> no stall, o_data_b=0.
REQ-026 i_ready=0 for 4 cycles with i_valid=1 -> output holds, two entries buffered, o_ready=0; i_ready=1 -> entries issue in order one per cycle, no loss/duplication.
REQ-027 Buffer full, clr=1 with i_valid=1 -> next cycle count=0, o_valid=0, o_ready=1, o_hazard_cycles=0; pushed entry discarded.
REQ-028 aresetn pulsed low mid-stream (async, between edges) -> o_valid=0 before next edge; after release, 0x200 push issues in one cycle.

Source files
------------

// File: rtl/id_fwd_skid.sv
// id_fwd_skid: decode-stage skid FIFO with operand forwarding.
// Entries are buffered in a small circular FIFO. The head reads the register
// file and the forwarding network combinationally. The first matching
// forward slot wins, and it stalls the head while that slot's data is pending.
// Resolved operands are launched into a registered output stage.
module id_fwd_skid #(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int REG_IDX_W  = 5,
    parameter int SKID_DEPTH = 2,
    parameter int NUM_FWD    = 3
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          clr,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [ADDR_W-1:0]             i_pc,
    input  logic [INSTR_W-1:0]            i_instr,
    input  logic                          i_use_a,
    input  logic                          i_use_b,
    output logic [REG_IDX_W-1:0]          o_rf_reg_a,
    output logic [REG_IDX_W-1:0]          o_rf_reg_b,
    input  logic [WORD_W-1:0]             i_rf_data_a,
    input  logic [WORD_W-1:0]             i_rf_data_b,
    input  logic [NUM_FWD-1:0]            i_fwd_en,
    input  logic [NUM_FWD-1:0]            i_fwd_pending,
    input  logic [NUM_FWD*REG_IDX_W-1:0]  i_fwd_reg,
    input  logic [NUM_FWD*WORD_W-1:0]     i_fwd_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ADDR_W-1:0]             o_pc,
    output logic [INSTR_W-1:0]            o_instr,
    output logic [REG_IDX_W-1:0]          o_dest_reg,
    output logic [WORD_W-1:0]             o_data_a,
    output logic [WORD_W-1:0]             o_data_b,
    output logic [15:0]                   o_hazard_cycles
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(SKID_DEPTH);

    logic [ADDR_W-1:0]     r_pc_mem    [SKID_DEPTH];
    logic [INSTR_W-1:0]    r_instr_mem [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] r_ua_mem;
    logic [SKID_DEPTH-1:0] r_ub_mem;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_push, w_pop, w_load, w_head_vld, w_blocked;
    logic [ADDR_W-1:0]     w_head_pc;
    logic [INSTR_W-1:0]    w_head_instr;
    logic                  w_head_ua, w_head_ub;
    logic [WORD_W:0]       w_res_a, w_res_b;

    // Priority operand lookup; MSB of the result flags a pending (blocking) hit.
    function automatic logic [WORD_W:0] f_resolve(
        input logic                         use_s,
        input logic [REG_IDX_W-1:0]         idx,
        input logic [WORD_W-1:0]            rf,
        input logic [NUM_FWD-1:0]           en,
        input logic [NUM_FWD-1:0]           pend,
        input logic [NUM_FWD*REG_IDX_W-1:0] regs,
        input logic [NUM_FWD*WORD_W-1:0]    data
    );
        logic            found;
        logic [WORD_W:0] res;
        found = 1'b0;
        res   = {1'b0, rf};
        if (!use_s || idx == '0) begin
            res = '0;
        end else begin
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!found && en[k] && regs[k*REG_IDX_W +: REG_IDX_W] == idx) begin
                    found = 1'b1;
                    res   = pend[k] ? {1'b1, {WORD_W{1'b0}}}
                                    : {1'b0, data[k*WORD_W +: WORD_W]};
                end
            end
        end
        return res;
    endfunction

    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_instr = r_instr_mem[r_rd_ptr];
    assign w_head_ua    = r_ua_mem[r_rd_ptr];
    assign w_head_ub    = r_ub_mem[r_rd_ptr];
    assign o_rf_reg_a   = w_head_instr[19:15];
    assign o_rf_reg_b   = w_head_instr[24:20];

    assign w_res_a = f_resolve(w_head_ua, o_rf_reg_a, i_rf_data_a,
                               i_fwd_en, i_fwd_pending, i_fwd_reg, i_fwd_data);
    assign w_res_b = f_resolve(w_head_ub, o_rf_reg_b, i_rf_data_b,
                               i_fwd_en, i_fwd_pending, i_fwd_reg, i_fwd_data);

    assign o_ready    = (r_count < DEPTH_C);
    assign w_head_vld = (r_count != '0);
    assign w_blocked  = w_res_a[WORD_W] | w_res_b[WORD_W];
    assign w_load     = ~o_valid | i_ready;
    assign w_push     = i_valid & o_ready;
    assign w_pop      = w_load & w_head_vld & ~w_blocked;

    // Entry storage: payload needs no reset, only pointers/count gate validity.
    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_pc_mem[r_wr_ptr]    <= i_pc;
            r_instr_mem[r_wr_ptr] <= i_instr;
            r_ua_mem[r_wr_ptr]    <= i_use_a;
            r_ub_mem[r_wr_ptr]    <= i_use_b;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: load the resolved head or insert a bubble.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_instr    <= '0;
            o_dest_reg <= '0;
            o_data_a   <= '0;
            o_data_b   <= '0;
        end else if (clr) begin
            o_valid    <= 1'b0;
        end else if (w_load) begin
            o_valid <= w_pop;
            if (w_pop) begin
                o_pc       <= w_head_pc;
                o_instr    <= w_head_instr;
                o_dest_reg <= w_head_instr[11:7];
                o_data_a   <= w_res_a[WORD_W-1:0];
                o_data_b   <= w_res_b[WORD_W-1:0];
            end
        end
    end

    // Saturating count of cycles the head could have issued but was blocked.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_hazard_cycles <= '0;
        end else if (clr) begin
            o_hazard_cycles <= '0;
        end else if (w_head_vld && w_blocked && w_load && o_hazard_cycles != 16'hFFFF) begin
            o_hazard_cycles <= o_hazard_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_fwd_skid.sv
// Directed bench for id_fwd_skid: forwarding priority, hazards, skid, flush, reset.
module tb_id_fwd_skid;
    logic        clk = 1'b0;
    logic        aresetn, clr, i_valid, o_ready;
    logic [31:0] i_pc, i_instr;
    logic        i_use_a, i_use_b;
    logic [4:0]  o_rf_reg_a, o_rf_reg_b;
    logic [31:0] i_rf_data_a, i_rf_data_b;
    logic [2:0]  i_fwd_en, i_fwd_pending;
    logic [14:0] i_fwd_reg;
    logic [95:0] i_fwd_data;
    logic        o_valid, i_ready;
    logic [31:0] o_pc, o_instr;
    logic [4:0]  o_dest_reg;
    logic [31:0] o_data_a, o_data_b;
    logic [15:0] o_hazard_cycles;

    int n_cmp = 0;
    int n_err = 0;

    id_fwd_skid dut (
        .clk(clk), .aresetn(aresetn), .clr(clr), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_instr(i_instr), .i_use_a(i_use_a), .i_use_b(i_use_b),
        .o_rf_reg_a(o_rf_reg_a), .o_rf_reg_b(o_rf_reg_b),
        .i_rf_data_a(i_rf_data_a), .i_rf_data_b(i_rf_data_b),
        .i_fwd_en(i_fwd_en), .i_fwd_pending(i_fwd_pending),
        .i_fwd_reg(i_fwd_reg), .i_fwd_data(i_fwd_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instr(o_instr),
        .o_dest_reg(o_dest_reg), .o_data_a(o_data_a), .o_data_b(o_data_b),
        .o_hazard_cycles(o_hazard_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    task automatic set_fwd(input int k, input logic en, input logic pend,
                           input logic [4:0] r, input logic [31:0] d);
        i_fwd_en[k]          = en;
        i_fwd_pending[k]     = pend;
        i_fwd_reg[k*5 +: 5]  = r;
        i_fwd_data[k*32 +: 32] = d;
    endtask

    initial begin
        aresetn = 1'b0; clr = 1'b0; i_valid = 1'b0; i_pc = '0; i_instr = '0;
        i_use_a = 1'b0; i_use_b = 1'b0; i_rf_data_a = '0; i_rf_data_b = '0;
        i_fwd_en = '0; i_fwd_pending = '0; i_fwd_reg = '0; i_fwd_data = '0;
        i_ready = 1'b1;
        #2;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_haz", {16'd0, o_hazard_cycles}, 32'd0);
        check("rst_pc", o_pc, 32'd0);
        step(); step();
        aresetn = 1'b1;
        step();

        // Plain register-file read, one-cycle latency
        i_valid = 1'b1; i_pc = 32'h100; i_instr = mk(5'd1, 5'd3, 5'd7);
        i_use_a = 1'b1; i_use_b = 1'b0; i_rf_data_a = 32'h11; i_rf_data_b = 32'h99;
        step();
        i_valid = 1'b0;
        check("lat_not_yet", {31'd0, o_valid}, 32'd0);
        check("rf_reg_a", {27'd0, o_rf_reg_a}, 32'd3);
        step();
        check("lat_valid", {31'd0, o_valid}, 32'd1);
        check("lat_pc", o_pc, 32'h100);
        check("lat_data_a", o_data_a, 32'h11);
        check("lat_data_b_unused", o_data_b, 32'd0);
        check("lat_dest", {27'd0, o_dest_reg}, 32'd1);

        // Forward priority: slot1 beats slot2
        i_valid = 1'b1; i_pc = 32'h104; i_instr = mk(5'd2, 5'd5, 5'd0);
        set_fwd(1, 1'b1, 1'b0, 5'd5, 32'hAA);
        set_fwd(2, 1'b1, 1'b0, 5'd5, 32'hBB);
        step();
        i_valid = 1'b0;
        step();
        check("fwd_prio_valid", {31'd0, o_valid}, 32'd1);
        check("fwd_prio_data", o_data_a, 32'hAA);

        // Pending slot0 blocks even though slot1 has ready data
        i_valid = 1'b1; i_pc = 32'h108; i_instr = mk(5'd4, 5'd5, 5'd0);
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h0);
        step();
        i_valid = 1'b0;
        check("haz_bubble0", {31'd0, o_valid}, 32'd0);
        check("haz_cnt0", {16'd0, o_hazard_cycles}, 32'd0);
        step();
        check("haz_bubble1", {31'd0, o_valid}, 32'd0);
        check("haz_cnt1", {16'd0, o_hazard_cycles}, 32'd1);
        step();
        check("haz_cnt2", {16'd0, o_hazard_cycles}, 32'd2);
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'hCC);
        step();
        check("haz_release_valid", {31'd0, o_valid}, 32'd1);
        check("haz_release_pc", o_pc, 32'h108);
        check("haz_release_data", o_data_a, 32'hCC);
        check("haz_cnt_hold", {16'd0, o_hazard_cycles}, 32'd2);
        i_fwd_en = '0; i_fwd_pending = '0;

        // Register 0 never hazards and reads as zero
        i_valid = 1'b1; i_pc = 32'h10C; i_instr = mk(5'd6, 5'd3, 5'd0);
        i_use_a = 1'b1; i_use_b = 1'b1; i_rf_data_b = 32'h55;
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hEE);
        step();
        i_valid = 1'b0;
        step();
        check("r0_valid", {31'd0, o_valid}, 32'd1);
        check("r0_data_b", o_data_b, 32'd0);
        check("r0_data_a", o_data_a, 32'h11);
        check("r0_haz", {16'd0, o_hazard_cycles}, 32'd2);
        i_fwd_en = '0; i_fwd_pending = '0;
        i_use_a = 1'b0; i_use_b = 1'b0;

        // Downstream stall: output holds, two entries skid, then drain in order
        i_ready = 1'b0;
        i_valid = 1'b1; i_pc = 32'h300; i_instr = mk(5'd8, 5'd0, 5'd0);
        step();
        i_pc = 32'h304; i_instr = mk(5'd9, 5'd0, 5'd0);
        step();
        check("skid_full_ready", {31'd0, o_ready}, 32'd0);
        i_pc = 32'h3FC;
        step(); step();
        check("stall_valid", {31'd0, o_valid}, 32'd1);
        check("stall_pc_hold", o_pc, 32'h10C);
        check("stall_ready", {31'd0, o_ready}, 32'd0);
        i_valid = 1'b0; i_ready = 1'b1;
        step();
        check("drain0_pc", o_pc, 32'h300);
        check("drain0_dest", {27'd0, o_dest_reg}, 32'd8);
        check("drain0_ready", {31'd0, o_ready}, 32'd1);
        step();
        check("drain1_valid", {31'd0, o_valid}, 32'd1);
        check("drain1_pc", o_pc, 32'h304);
        step();
        check("drain_empty", {31'd0, o_valid}, 32'd0);

        // Flush with buffer full overrides concurrent push
        i_ready = 1'b0;
        i_valid = 1'b1; i_pc = 32'h400;
        step();
        i_pc = 32'h404;
        step();
        i_pc = 32'h408;
        step();
        check("pre_clr_ready", {31'd0, o_ready}, 32'd0);
        check("pre_clr_pc", o_pc, 32'h400);
        clr = 1'b1; i_pc = 32'h40C;
        step();
        clr = 1'b0; i_valid = 1'b0;
        check("clr_valid", {31'd0, o_valid}, 32'd0);
        check("clr_ready", {31'd0, o_ready}, 32'd1);
        check("clr_haz", {16'd0, o_hazard_cycles}, 32'd0);
        i_ready = 1'b1;
        step();
        check("clr_discard", {31'd0, o_valid}, 32'd0);

        // Async reset mid-stream
        i_valid = 1'b1; i_pc = 32'h500;
        step();
        i_pc = 32'h504;
        step();
        i_valid = 1'b0;
        check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, o_valid}, 32'd0);
        check("async_rst_pc", o_pc, 32'd0);
        check("async_rst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #3 aresetn = 1'b1;
        step();
        check("post_rst_empty", {31'd0, o_valid}, 32'd0);
        i_valid = 1'b1; i_pc = 32'h200; i_instr = mk(5'd1, 5'd3, 5'd0);
        i_use_a = 1'b1; i_rf_data_a = 32'h11;
        step();
        i_valid = 1'b0;
        check("post_rst_lat0", {31'd0, o_valid}, 32'd0);
        step();
        check("post_rst_valid", {31'd0, o_valid}, 32'd1);
        check("post_rst_pc", o_pc, 32'h200);
        check("post_rst_data", o_data_a, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
